// File: rtl/axis_to_lbus_rx_pkg.sv
// Shared LBUS geometry, receive-FSM state encoding and keep helpers.
package axis_to_lbus_rx_pkg;

  localparam int NUM_SEG   = 4;
  localparam int SEG_W     = 128;
  localparam int SEG_BYTES = SEG_W / 8;
  localparam int MTY_W     = 4;
  localparam int SEG_IDX_W = $clog2(NUM_SEG);
  localparam int AXIS_W    = NUM_SEG * SEG_W;
  localparam int KEEP_W    = AXIS_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BODY = 2'd1,
    ST_GAP  = 2'd2
  } rx_state_e;

  // True when keep is a run of ones starting at bit 0 (zero also qualifies).
  function automatic logic keep_is_prefix(input logic [KEEP_W-1:0] k);
    return ((k & (k + KEEP_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/axis_to_lbus_rx_seg_encode.sv
// Per-segment keep decode: enable, last-byte-valid and empty-byte count.
module lbus_seg_encode
  import axis_to_lbus_rx_pkg::*;
(
  input  logic [SEG_BYTES-1:0] keep,
  output logic                 en,
  output logic                 last_vld,
  output logic [MTY_W-1:0]     mty
);

  localparam int CNT_W = $clog2(SEG_BYTES) + 1;

  logic [CNT_W-1:0] cnt;

  // Population count of kept bytes in this segment.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < SEG_BYTES; i++) cnt = cnt + CNT_W'(keep[i]);
  end

  assign en       = |keep;
  assign last_vld = keep[SEG_BYTES-1];
  // An empty segment cannot express 16 in MTY_W bits; it saturates to 15.
  assign mty      = (cnt == '0) ? MTY_W'(SEG_BYTES - 1)
                                : MTY_W'(CNT_W'(SEG_BYTES) - cnt);

endmodule

// File: rtl/axis_to_lbus_rx.sv
// 512-bit AXI4-Stream to 4-segment CMAC LBUS RX converter with inter-packet gap.
module axis_to_lbus_rx
  import axis_to_lbus_rx_pkg::*;
#(
  parameter int MIN_GAP = 1
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [AXIS_W-1:0]          S_AXIS_TDATA,
  input  logic [KEEP_W-1:0]          S_AXIS_TKEEP,
  input  logic                       S_AXIS_TLAST,
  input  logic                       S_AXIS_TVALID,
  output logic                       S_AXIS_TREADY,
  input  logic                       ERR_INJECT,
  output logic [AXIS_W-1:0]          LBUS_RX_DATA,
  output logic [NUM_SEG-1:0]         LBUS_RX_EN,
  output logic [NUM_SEG-1:0]         LBUS_RX_SOP,
  output logic [NUM_SEG-1:0]         LBUS_RX_EOP,
  output logic [NUM_SEG-1:0]         LBUS_RX_ERR,
  output logic [NUM_SEG*MTY_W-1:0]   LBUS_RX_MTY,
  output logic [31:0]                PKT_CNT,
  output logic [31:0]                ERR_CNT
);

  rx_state_e                       state, state_n;
  logic [7:0]                      gap_cnt;
  logic                            sticky_err, tready_q;
  logic                            accept, keep_zero, frm_err, pkt_err;
  logic [NUM_SEG-1:0]              seg_en, seg_lv;
  logic [NUM_SEG-1:0][MTY_W-1:0]   seg_mty;
  logic [SEG_IDX_W-1:0]            eop_idx;
  logic [AXIS_W-1:0]               data_swz;
  logic [NUM_SEG-1:0]              en_c, eop_c, err_c;
  logic [NUM_SEG-1:0][MTY_W-1:0]   mty_c;

  assign S_AXIS_TREADY = tready_q;
  assign accept        = S_AXIS_TVALID & tready_q;

  // Segment decode plus big-endian byte placement inside each segment.
  for (genvar g = 0; g < NUM_SEG; g++) begin : g_seg
    lbus_seg_encode u_enc (
      .keep     (S_AXIS_TKEEP[g*SEG_BYTES +: SEG_BYTES]),
      .en       (seg_en[g]),
      .last_vld (seg_lv[g]),
      .mty      (seg_mty[g])
    );
    for (genvar b = 0; b < SEG_BYTES; b++) begin : g_byte
      assign data_swz[g*SEG_W + (SEG_BYTES-1-b)*8 +: 8] = S_AXIS_TDATA[(g*SEG_BYTES+b)*8 +: 8];
    end
  end

  // A mid-packet beat must be fully kept: every segment ends valid with no empties.
  assign keep_zero = (S_AXIS_TKEEP == '0);
  assign frm_err   = keep_zero |
                     (S_AXIS_TLAST ? !keep_is_prefix(S_AXIS_TKEEP)
                                   : !((&seg_lv) && (seg_mty == '0)));
  assign pkt_err   = sticky_err | frm_err | ERR_INJECT;

  // EOP lands on the highest populated segment; an all-empty last beat uses segment 0.
  always_comb begin
    eop_idx = '0;
    for (int i = 0; i < NUM_SEG; i++) if (seg_en[i]) eop_idx = SEG_IDX_W'(i);
  end

  // Per-cycle LBUS control fields for the beat on the bus.
  always_comb begin
    en_c  = seg_en;
    eop_c = '0;
    err_c = '0;
    mty_c = '0;
    if (S_AXIS_TLAST) begin
      if (keep_zero) en_c[0] = 1'b1;
      eop_c[eop_idx] = 1'b1;
      err_c[eop_idx] = pkt_err;
      mty_c[eop_idx] = seg_mty[eop_idx];
    end
  end

  // Next-state logic: IDLE marks the start of a packet, GAP throttles the source.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE, ST_BODY: begin
        if (accept) begin
          if (!S_AXIS_TLAST)     state_n = ST_BODY;
          else if (MIN_GAP == 0) state_n = ST_IDLE;
          else                   state_n = ST_GAP;
        end
      end
      ST_GAP:  if (gap_cnt == '0) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Control state: FSM, ready (registered so it is low throughout reset), gap timer, sticky error.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= ST_IDLE;
      tready_q   <= 1'b0;
      gap_cnt    <= '0;
      sticky_err <= 1'b0;
    end else begin
      state    <= state_n;
      tready_q <= (state_n != ST_GAP);
      if (accept && S_AXIS_TLAST)          gap_cnt <= 8'(MIN_GAP - 1);
      else if (state == ST_GAP && gap_cnt != '0) gap_cnt <= gap_cnt - 8'd1;
      if (accept) sticky_err <= S_AXIS_TLAST ? 1'b0 : (sticky_err | frm_err);
    end
  end

  // Registered LBUS outputs and packet counters, one cycle after the accepting edge.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      LBUS_RX_DATA <= '0;
      LBUS_RX_EN   <= '0;
      LBUS_RX_SOP  <= '0;
      LBUS_RX_EOP  <= '0;
      LBUS_RX_ERR  <= '0;
      LBUS_RX_MTY  <= '0;
      PKT_CNT      <= '0;
      ERR_CNT      <= '0;
    end else begin
      LBUS_RX_EN  <= accept ? en_c  : '0;
      LBUS_RX_EOP <= accept ? eop_c : '0;
      LBUS_RX_ERR <= accept ? err_c : '0;
      LBUS_RX_MTY <= accept ? mty_c : '0;
      LBUS_RX_SOP <= {{(NUM_SEG-1){1'b0}}, accept && (state == ST_IDLE)};
      if (accept) LBUS_RX_DATA <= data_swz;
      if (accept && S_AXIS_TLAST) begin
        PKT_CNT <= PKT_CNT + 32'd1;
        if (pkt_err) ERR_CNT <= ERR_CNT + 32'd1;
      end
    end
  end

endmodule
